// File: rtl/multi_clock_divider.sv
// NUM_CH independent runtime-programmable clock dividers sharing one system clock.
// Each channel emits a 50%-duty divided clock plus a one-cycle tick on every toggle.
module multi_clock_divider #(
  parameter  int NUM_CH      = 2,
  parameter  int CNT_W       = 32,
  parameter  int DEFAULT_DIV = 25000000,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              in_clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              div_wr_en,
  input  logic [CH_W-1:0]   div_wr_ch,
  input  logic [CNT_W-1:0]  div_wr_data,
  output logic [NUM_CH-1:0] out_clk,
  output logic [NUM_CH-1:0] tick,
  output logic              div_err
);

  logic [CNT_W-1:0]  r_div [NUM_CH];
  logic [CNT_W-1:0]  r_cnt [NUM_CH];
  logic [NUM_CH-1:0] r_out_clk;
  logic [NUM_CH-1:0] r_tick;
  logic              r_div_err;

  logic              w_wr_valid;
  logic              w_wr_accept;
  logic              w_wr_reject;
  logic [NUM_CH-1:0] w_wr_hit;
  logic [NUM_CH-1:0] w_term;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    w_wr_hit    = '0;
    w_term      = '0;
    w_wr_valid  = (div_wr_data != '0) && (int'(div_wr_ch) < NUM_CH);
    w_wr_accept = div_wr_en && w_wr_valid;
    w_wr_reject = div_wr_en && !w_wr_valid;
    for (int i = 0; i < NUM_CH; i++) begin
      w_wr_hit[i] = w_wr_accept && (int'(div_wr_ch) == i);
      w_term[i]   = (r_cnt[i] == (r_div[i] - CNT_W'(1)));
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge in_clk) begin
    if (!rst) begin
      r_out_clk <= '0;
      r_tick    <= '0;
      r_div_err <= 1'b0;
      // NOTE: the divisor array is reset on purpose: each channel must restart from DEFAULT_DIV.
      for (int i = 0; i < NUM_CH; i++) begin
        r_div[i] <= CNT_W'(DEFAULT_DIV);
        r_cnt[i] <= '0;
      end
    end else begin
      r_div_err <= w_wr_reject;
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_wr_hit[i]) begin
          // A write restarts the phase; a coincident terminal count is dropped.
          r_div[i]  <= div_wr_data;
          r_cnt[i]  <= '0;
          r_tick[i] <= 1'b0;
        end else if (!en[i]) begin
          r_tick[i] <= 1'b0;
        end else if (w_term[i]) begin
          r_cnt[i]     <= '0;
          r_out_clk[i] <= ~r_out_clk[i];
          r_tick[i]    <= 1'b1;
        end else begin
          r_cnt[i]  <= r_cnt[i] + CNT_W'(1);
          r_tick[i] <= 1'b0;
        end
      end
    end
  end

  assign out_clk = r_out_clk;
  assign tick    = r_tick;
  assign div_err = r_div_err;

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed bench for multi_clock_divider: a vector table for steady-state behaviour
// plus hand-written sequences for enable freeze, mid-period reset and channel range.
module tb_multi_clock_divider;

  logic       in_clk;
  logic       rst;
  logic [1:0] en;
  logic       div_wr_en;
  logic       div_wr_ch;
  logic [7:0] div_wr_data;
  logic [1:0] out_clk;
  logic [1:0] tick;
  logic       div_err;

  logic [2:0] en3;
  logic       wr3;
  logic [1:0] ch3;
  logic [7:0] data3;
  logic [2:0] out3;
  logic [2:0] tick3;
  logic       err3;

  int n_checks = 0;
  int n_fail   = 0;

  multi_clock_divider #(.NUM_CH(2), .CNT_W(8), .DEFAULT_DIV(4)) u_dut (
    .in_clk(in_clk), .rst(rst), .en(en), .div_wr_en(div_wr_en),
    .div_wr_ch(div_wr_ch), .div_wr_data(div_wr_data),
    .out_clk(out_clk), .tick(tick), .div_err(div_err)
  );

  multi_clock_divider #(.NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(4)) u_dut3 (
    .in_clk(in_clk), .rst(rst), .en(en3), .div_wr_en(wr3),
    .div_wr_ch(ch3), .div_wr_data(data3),
    .out_clk(out3), .tick(tick3), .div_err(err3)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  typedef struct {
    logic [1:0] en;
    logic       wr;
    logic       ch;
    logic [7:0] data;
    logic [1:0] out;
    logic [1:0] tick;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [1:0] e, input logic w, input logic c, input logic [7:0] d,
                     input logic [1:0] o, input logic [1:0] t, input logic er);
    vec_t v;
    v.en = e; v.wr = w; v.ch = c; v.data = d; v.out = o; v.tick = t; v.err = er;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
  task automatic step();
    @(posedge in_clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] e, input logic w, input logic c, input logic [7:0] d);
    en = e; div_wr_en = w; div_wr_ch = c; div_wr_data = d;
  endtask

  initial begin
    rst = 1'b0;
    drive(2'b11, 1'b1, 1'b0, 8'd7);
    en3 = 3'b000; wr3 = 1'b0; ch3 = 2'd0; data3 = 8'd0;

    // Expected outputs after each edge; output buses are {ch1, ch0}.
    for (int i = 0; i < 3; i++) add(2'b11, 0, 0, 8'd0, 2'b00, 2'b00, 0);
    add(2'b11, 0, 0, 8'd0, 2'b11, 2'b11, 0);
    for (int i = 0; i < 3; i++) add(2'b11, 0, 0, 8'd0, 2'b11, 2'b00, 0);
    add(2'b11, 0, 0, 8'd0, 2'b00, 2'b11, 0);
    add(2'b11, 1, 1, 8'd1, 2'b00, 2'b00, 0);
    add(2'b11, 0, 0, 8'd0, 2'b10, 2'b10, 0);
    add(2'b11, 0, 0, 8'd0, 2'b00, 2'b10, 0);
    add(2'b11, 0, 0, 8'd0, 2'b11, 2'b11, 0);
    add(2'b11, 0, 0, 8'd0, 2'b01, 2'b10, 0);
    add(2'b11, 0, 0, 8'd0, 2'b11, 2'b10, 0);
    add(2'b00, 1, 0, 8'd0, 2'b11, 2'b00, 1);
    add(2'b00, 0, 0, 8'd0, 2'b11, 2'b00, 0);
    add(2'b11, 0, 0, 8'd0, 2'b01, 2'b10, 0);
    add(2'b11, 0, 0, 8'd0, 2'b10, 2'b11, 0);
    for (int i = 0; i < 3; i++) add(2'b01, 0, 0, 8'd0, 2'b10, 2'b00, 0);
    add(2'b01, 1, 0, 8'd6, 2'b10, 2'b00, 0);
    for (int i = 0; i < 5; i++) add(2'b01, 0, 0, 8'd0, 2'b10, 2'b00, 0);
    add(2'b01, 0, 0, 8'd0, 2'b11, 2'b01, 0);
    add(2'b01, 1, 0, 8'd4, 2'b11, 2'b00, 0);
    for (int i = 0; i < 2; i++) add(2'b01, 0, 0, 8'd0, 2'b11, 2'b00, 0);

    step();
    step();
    check("reset_state", {27'd0, out_clk, tick, div_err}, 32'd0);

    rst = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].wr, vecs[i].ch, vecs[i].data);
      step();
      check($sformatf("vec%0d", i), {27'd0, out_clk, tick, div_err},
            {27'd0, vecs[i].out, vecs[i].tick, vecs[i].err});
    end

    // Ch0 (div 4) is frozen at count 2 for 10 cycles, then needs 2 more enabled cycles.
    drive(2'b00, 0, 0, 8'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("freeze%0d", i), {28'd0, out_clk, tick}, {28'd0, 2'b11, 2'b00});
    end
    drive(2'b01, 0, 0, 8'd0);
    step();
    check("resume1", {28'd0, out_clk, tick}, {28'd0, 2'b11, 2'b00});
    step();
    check("resume2_toggle", {28'd0, out_clk, tick}, {28'd0, 2'b10, 2'b01});

    // Run ch0 to out_clk=1 and one cycle into the high phase, then reset.
    for (int i = 0; i < 3; i++) step();
    check("pre_rst_low", {30'd0, out_clk}, {30'd0, 2'b10});
    step();
    check("pre_rst_rise", {28'd0, out_clk, tick}, {28'd0, 2'b11, 2'b01});
    step();
    check("pre_rst_mid", {28'd0, out_clk, tick}, {28'd0, 2'b11, 2'b00});

    rst = 1'b0;
    drive(2'b11, 1, 0, 8'd9);
    step();
    check("rst_mid_outputs", {27'd0, out_clk, tick, div_err}, 32'd0);
    drive(2'b11, 1, 1, 8'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("rst_hold%0d", i), {27'd0, out_clk, tick, div_err}, 32'd0);
    end

    rst = 1'b1;
    drive(2'b11, 0, 0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("post_rst%0d", i), {28'd0, out_clk, tick}, 32'd0);
    end
    step();
    check("post_rst_default_div", {28'd0, out_clk, tick}, {28'd0, 2'b11, 2'b11});

    // Three-channel build: channel 3 is out of range, channel 2 is valid.
    wr3 = 1'b1; ch3 = 2'd3; data3 = 8'd5;
    step();
    check("ch_range_err", {28'd0, out3, err3}, {28'd0, 3'b000, 1'b1});
    wr3 = 1'b0;
    step();
    check("ch_range_err_clear", {31'd0, err3}, 32'd0);
    wr3 = 1'b1; ch3 = 2'd0; data3 = 8'd0;
    step();
    check("zero_div_err", {31'd0, err3}, 32'd1);
    wr3 = 1'b1; ch3 = 2'd2; data3 = 8'd1;
    step();
    check("ch2_write_ok", {31'd0, err3}, 32'd0);
    wr3 = 1'b0; en3 = 3'b100;
    step();
    check("ch2_div1_a", {26'd0, out3, tick3}, {26'd0, 3'b100, 3'b100});
    step();
    check("ch2_div1_b", {26'd0, out3, tick3}, {26'd0, 3'b000, 3'b100});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
